// File: rtl/ps2_cursor_pkg.sv
// Shared types and header bit positions for the PS/2 mouse packet decoder.
package ps2_cursor_pkg;

   typedef enum logic [2:0] {
      ST_B0,
      ST_B1,
      ST_B2,
      ST_B3,
      ST_APPLY
   } state_t;

   localparam int HDR_LEFT  = 0;
   localparam int HDR_RIGHT = 1;
   localparam int HDR_MID   = 2;
   localparam int HDR_SYNC  = 3;
   localparam int HDR_XSIGN = 4;
   localparam int HDR_YSIGN = 5;
   localparam int HDR_XOVF  = 6;
   localparam int HDR_YOVF  = 7;

   // Header fields kept after framing; the sync bit is consumed by the FSM.
   typedef struct packed {
      logic y_ovf;
      logic x_ovf;
      logic y_sign;
      logic x_sign;
      logic mid;
      logic right;
      logic left;
   } hdr_t;

endpackage

// File: rtl/ps2_delta_clamp.sv
// Adds (or subtracts) a scaled signed 9-bit delta to a position and clamps
// the result to [0, LIMIT-1].
module ps2_delta_clamp #(
   parameter int POS_W       = 10,
   parameter int LIMIT       = 640,
   parameter int SPEED_SHIFT = 0,
   parameter bit SUBTRACT    = 1'b0
) (
   input  logic [POS_W-1:0] pos,
   input  logic signed [8:0] delta,
   output logic [POS_W-1:0] result
);

   localparam int SW = POS_W + SPEED_SHIFT + 3;
   localparam logic signed [SW-1:0] MAX_POS = SW'(LIMIT - 1);

   logic signed [SW-1:0] delta_ext;
   logic signed [SW-1:0] pos_ext;
   logic signed [SW-1:0] sum;

   always_comb begin
      delta_ext = {{(SW-9){delta[8]}}, delta} <<< SPEED_SHIFT;
      pos_ext   = {{(SW-POS_W){1'b0}}, pos};
      sum       = SUBTRACT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
      if (sum < 0)
         result = '0;
      else if (sum > MAX_POS)
         result = MAX_POS[POS_W-1:0];
      else
         result = sum[POS_W-1:0];
   end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// PS/2 mouse packet assembler and clamped cursor tracker with button edges,
// wheel accumulation and framing/timeout error reporting.
module ps2_cursor_tracker
   import ps2_cursor_pkg::*;
#(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int POS_W       = 10,
   parameter int PKT_BYTES   = 3,
   parameter int SPEED_SHIFT = 0,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic             iCLK_50,
   input  logic             iRST_n,
   input  logic [7:0]       iBYTE,
   input  logic             iBYTE_VALID,
   input  logic             iCLR,
   output logic [POS_W-1:0] oX,
   output logic [POS_W-1:0] oY,
   output logic             oLEFBUT,
   output logic             oRIGBUT,
   output logic             oMIDBUT,
   output logic             oLEFT_CLICK,
   output logic             oRIGHT_CLICK,
   output logic [7:0]       oWHEEL,
   output logic             oPKT_VALID,
   output logic             oSYNC_ERR,
   output logic [15:0]      oPKT_CNT
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [POS_W-1:0] X_CENTER = POS_W'(SCREEN_W / 2);
   localparam logic [POS_W-1:0] Y_CENTER = POS_W'(SCREEN_H / 2);

   state_t           state;
   state_t           state_next;
   hdr_t             hdr;
   logic [7:0]       x_byte;
   logic [7:0]       y_byte;
   logic [3:0]       w_nib;
   logic [CNT_W-1:0] idle_cnt;
   logic             load_hdr, load_x, load_y, load_w;
   logic             sync_err_next;
   logic             timed_out;
   logic             apply;
   logic signed [8:0] dx, dy;
   logic signed [8:0] wheel_sum;
   logic [7:0]       wheel_sat;
   logic [POS_W-1:0] x_next, y_next;

   always_ff @(posedge iCLK_50 or negedge iRST_n) begin
      if (!iRST_n)
         state <= ST_B0;
      else
         state <= state_next;
   end

   // APPLY behaves like B0 for incoming bytes so streamed packets are not lost.
   always_comb begin
      state_next    = state;
      load_hdr      = 1'b0;
      load_x        = 1'b0;
      load_y        = 1'b0;
      load_w        = 1'b0;
      sync_err_next = 1'b0;
      timed_out     = (state == ST_B1 || state == ST_B2 || state == ST_B3) &&
                      !iBYTE_VALID && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
      case (state)
         ST_B0, ST_APPLY: begin
            state_next = ST_B0;
            if (iBYTE_VALID) begin
               if (iBYTE[HDR_SYNC]) begin
                  load_hdr   = 1'b1;
                  state_next = ST_B1;
               end else begin
                  sync_err_next = 1'b1;
               end
            end
         end
         ST_B1: begin
            if (iBYTE_VALID) begin
               load_x     = 1'b1;
               state_next = ST_B2;
            end
         end
         ST_B2: begin
            if (iBYTE_VALID) begin
               load_y     = 1'b1;
               state_next = (PKT_BYTES == 4) ? ST_B3 : ST_APPLY;
            end
         end
         ST_B3: begin
            if (iBYTE_VALID) begin
               load_w     = 1'b1;
               state_next = ST_APPLY;
            end
         end
         default: state_next = ST_B0;
      endcase
      if (timed_out) begin
         state_next    = ST_B0;
         sync_err_next = 1'b1;
      end
   end

   always_ff @(posedge iCLK_50 or negedge iRST_n) begin
      if (!iRST_n) begin
         hdr      <= '0;
         x_byte   <= '0;
         y_byte   <= '0;
         w_nib    <= '0;
         idle_cnt <= '0;
      end else begin
         if (load_hdr)
            hdr <= '{y_ovf:  iBYTE[HDR_YOVF],  x_ovf: iBYTE[HDR_XOVF],
                     y_sign: iBYTE[HDR_YSIGN], x_sign: iBYTE[HDR_XSIGN],
                     mid:    iBYTE[HDR_MID],   right: iBYTE[HDR_RIGHT],
                     left:   iBYTE[HDR_LEFT]};
         if (load_x) x_byte <= iBYTE;
         if (load_y) y_byte <= iBYTE;
         if (load_w) w_nib  <= iBYTE[3:0];
         if (iBYTE_VALID || state == ST_B0 || state == ST_APPLY || timed_out)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign apply = (state == ST_APPLY);

   always_comb begin
      dx        = hdr.x_ovf ? 9'sd0 : $signed({hdr.x_sign, x_byte});
      dy        = hdr.y_ovf ? 9'sd0 : $signed({hdr.y_sign, y_byte});
      wheel_sum = $signed({oWHEEL[7], oWHEEL}) + $signed({{5{w_nib[3]}}, w_nib});
      if (wheel_sum > 9'sd127)
         wheel_sat = 8'h7F;
      else if (wheel_sum < -9'sd128)
         wheel_sat = 8'h80;
      else
         wheel_sat = wheel_sum[7:0];
   end

   ps2_delta_clamp #(
      .POS_W(POS_W), .LIMIT(SCREEN_W), .SPEED_SHIFT(SPEED_SHIFT), .SUBTRACT(1'b0)
   ) u_clamp_x (
      .pos(oX), .delta(dx), .result(x_next)
   );

   // PS/2 positive Y is up while screen Y grows downwards.
   ps2_delta_clamp #(
      .POS_W(POS_W), .LIMIT(SCREEN_H), .SPEED_SHIFT(SPEED_SHIFT), .SUBTRACT(1'b1)
   ) u_clamp_y (
      .pos(oY), .delta(dy), .result(y_next)
   );

   always_ff @(posedge iCLK_50 or negedge iRST_n) begin
      if (!iRST_n) begin
         oX           <= X_CENTER;
         oY           <= Y_CENTER;
         oLEFBUT      <= 1'b0;
         oRIGBUT      <= 1'b0;
         oMIDBUT      <= 1'b0;
         oLEFT_CLICK  <= 1'b0;
         oRIGHT_CLICK <= 1'b0;
         oWHEEL       <= '0;
         oPKT_VALID   <= 1'b0;
         oSYNC_ERR    <= 1'b0;
         oPKT_CNT     <= '0;
      end else begin
         oPKT_VALID   <= apply;
         oSYNC_ERR    <= sync_err_next;
         oLEFT_CLICK  <= apply && hdr.left && !oLEFBUT;
         oRIGHT_CLICK <= apply && hdr.right && !oRIGBUT;
         if (iCLR) begin
            oX <= X_CENTER;
            oY <= Y_CENTER;
         end else if (apply) begin
            oX <= x_next;
            oY <= y_next;
         end
         if (apply) begin
            oLEFBUT  <= hdr.left;
            oRIGBUT  <= hdr.right;
            oMIDBUT  <= hdr.mid;
            oPKT_CNT <= oPKT_CNT + 16'd1;
            if (PKT_BYTES == 4)
               oWHEEL <= wheel_sat;
         end
      end
   end

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Randomised self-checking bench: a 3-byte and a 4-byte tracker driven from
// shared stimulus and compared against an integer reference model.
module tb_ps2_cursor_tracker;

   localparam int TMO = 40;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst_n;
   logic [7:0] tb_byte;
   logic       tb_valid, tb_clr;
   bit         sel;

   logic v3, v4, c3, c4;
   assign v3 = tb_valid & ~sel;
   assign v4 = tb_valid & sel;
   assign c3 = tb_clr & ~sel;
   assign c4 = tb_clr & sel;

   logic [9:0]  x3, y3, x4, y4;
   logic        l3, r3, m3, lc3, rc3, pv3, se3;
   logic        l4, r4, m4, lc4, rc4, pv4, se4;
   logic [7:0]  w3, w4;
   logic [15:0] n3, n4;

   ps2_cursor_tracker #(.PKT_BYTES(3), .SPEED_SHIFT(0), .TIMEOUT_CYC(TMO)) dut3 (
      .iCLK_50(clk), .iRST_n(rst_n), .iBYTE(tb_byte), .iBYTE_VALID(v3), .iCLR(c3),
      .oX(x3), .oY(y3), .oLEFBUT(l3), .oRIGBUT(r3), .oMIDBUT(m3),
      .oLEFT_CLICK(lc3), .oRIGHT_CLICK(rc3), .oWHEEL(w3), .oPKT_VALID(pv3),
      .oSYNC_ERR(se3), .oPKT_CNT(n3));

   ps2_cursor_tracker #(.PKT_BYTES(4), .SPEED_SHIFT(1), .TIMEOUT_CYC(TMO)) dut4 (
      .iCLK_50(clk), .iRST_n(rst_n), .iBYTE(tb_byte), .iBYTE_VALID(v4), .iCLR(c4),
      .oX(x4), .oY(y4), .oLEFBUT(l4), .oRIGBUT(r4), .oMIDBUT(m4),
      .oLEFT_CLICK(lc4), .oRIGHT_CLICK(rc4), .oWHEEL(w4), .oPKT_VALID(pv4),
      .oSYNC_ERR(se4), .oPKT_CNT(n4));

   logic [9:0]  cx, cy;
   logic        cl, cr, cm, clc, crc, cpv, cse;
   logic [7:0]  cw;
   logic [15:0] cn;

   always_comb begin
      cx  = sel ? x4  : x3;
      cy  = sel ? y4  : y3;
      cl  = sel ? l4  : l3;
      cr  = sel ? r4  : r3;
      cm  = sel ? m4  : m3;
      clc = sel ? lc4 : lc3;
      crc = sel ? rc4 : rc3;
      cpv = sel ? pv4 : pv3;
      cse = sel ? se4 : se3;
      cw  = sel ? w4  : w3;
      cn  = sel ? n4  : n3;
   end

   int       m_x[2], m_y[2], m_w[2], m_n[2];
   bit [2:0] m_btn[2];
   bit       m_lc, m_rc;
   int       checks = 0;
   int       failures = 0;

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference behaviour of one applied packet, in plain integer arithmetic.
   task automatic model_apply(input logic [7:0] b0, b1, b2, b3, input bit clr);
      int dx, dy, wn, gain;
      gain = sel ? 2 : 1;
      dx = int'(b1) - (b0[4] ? 256 : 0);
      dy = int'(b2) - (b0[5] ? 256 : 0);
      if (b0[6]) dx = 0;
      if (b0[7]) dy = 0;
      if (clr) begin
         m_x[sel] = 320;
         m_y[sel] = 240;
      end else begin
         m_x[sel] = clampi(m_x[sel] + dx * gain, 0, 639);
         m_y[sel] = clampi(m_y[sel] - dy * gain, 0, 479);
      end
      m_lc = b0[0] && !m_btn[sel][0];
      m_rc = b0[1] && !m_btn[sel][1];
      m_btn[sel] = b0[2:0];
      if (sel) begin
         wn = int'(b3[3:0]) - (b3[3] ? 16 : 0);
         m_w[sel] = clampi(m_w[sel] + wn, -128, 127);
      end
      m_n[sel] = (m_n[sel] + 1) % 65536;
   endtask

   task automatic send_packet(input logic [7:0] b0, b1, b2, b3, input bit with_clr,
                              input string tag);
      logic [7:0] bytes[4];
      int  n;
      bit  found;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      n = sel ? 4 : 3;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tb_byte  = bytes[i];
         tb_valid = 1'b1;
      end
      @(negedge clk);
      tb_valid = 1'b0;
      tb_clr   = with_clr;
      model_apply(b0, b1, b2, b3, with_clr);
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         @(negedge clk);
         tb_clr = 1'b0;
         if (cpv) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL %s pkt_valid: no pulse seen, expected one", tag);
      end
      checks++;
      if (cx !== 10'(m_x[sel]) || cy !== 10'(m_y[sel])) begin
         failures++;
         $display("[TB] FAIL %s pos: got (%0d,%0d) expected (%0d,%0d)", tag, cx, cy,
                  m_x[sel], m_y[sel]);
      end
      checks++;
      if ({cm, cr, cl} !== m_btn[sel] || clc !== m_lc || crc !== m_rc) begin
         failures++;
         $display("[TB] FAIL %s buttons: got btn=%b clk=%b%b expected btn=%b clk=%b%b",
                  tag, {cm, cr, cl}, crc, clc, m_btn[sel], m_rc, m_lc);
      end
      checks++;
      if (int'($signed(cw)) !== m_w[sel] || int'(cn) !== m_n[sel]) begin
         failures++;
         $display("[TB] FAIL %s wheel/cnt: got %0d/%0d expected %0d/%0d", tag,
                  $signed(cw), cn, m_w[sel], m_n[sel]);
      end
      @(negedge clk);
      checks++;
      if (cpv !== 1'b0 || clc !== 1'b0 || crc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s pulse_width: got pv=%b lc=%b rc=%b expected all 0",
                  tag, cpv, clc, crc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tb_valid = 1'b0; tb_clr = 1'b0; tb_byte = 8'h00; sel = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_x[s] = 320; m_y[s] = 240; m_w[s] = 0; m_n[s] = 0; m_btn[s] = 3'b000;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if (cx !== 10'd320 || cy !== 10'd240 || cn !== 16'd0 || cw !== 8'd0 ||
             {cl, cr, cm, clc, crc, cpv, cse} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset%0d: got x=%0d y=%0d cnt=%0d w=%0d flags=%b expected 320 240 0 0 0",
                     s, cx, cy, cn, cw, {cl, cr, cm, clc, crc, cpv, cse});
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_motion();
      sel = 1'b0;
      send_packet(8'h08, 8'h05, 8'h00, 8'h00, 1'b0, "move_right");
      checks++;
      if (cx !== 10'd325 || cy !== 10'd240 || cn !== 16'd1) begin
         failures++;
         $display("[TB] FAIL first_pkt: got x=%0d y=%0d cnt=%0d expected 325 240 1", cx, cy, cn);
      end
      send_packet(8'h28, 8'h00, 8'hF6, 8'h00, 1'b0, "move_down");
      send_packet(8'h18, 8'hFB, 8'h00, 8'h00, 1'b0, "move_left");
      checks++;
      if (cx !== 10'd320 || cy !== 10'd250) begin
         failures++;
         $display("[TB] FAIL neg_deltas: got x=%0d y=%0d expected 320 250", cx, cy);
      end
      send_packet(8'h08, 8'h7F, 8'h00, 8'h00, 1'b0, "to_574a");
      send_packet(8'h08, 8'h7F, 8'h00, 8'h00, 1'b0, "to_574b");
      send_packet(8'h08, 8'h38, 8'h00, 8'h00, 1'b0, "to_630");
      send_packet(8'h08, 8'h7F, 8'h00, 8'h00, 1'b0, "clamp_right");
      checks++;
      if (cx !== 10'd639) begin
         failures++;
         $display("[TB] FAIL clamp_x: got %0d expected 639", cx);
      end
      send_packet(8'h48, 8'hFF, 8'h00, 8'h00, 1'b0, "x_overflow");
      checks++;
      if (cx !== 10'd639) begin
         failures++;
         $display("[TB] FAIL xovf_hold: got %0d expected 639", cx);
      end
   endtask

   task automatic test_sync_err();
      sel = 1'b0;
      @(negedge clk);
      tb_byte = 8'h00; tb_valid = 1'b1;
      @(negedge clk);
      tb_valid = 1'b0;
      checks++;
      if (cse !== 1'b1 || cpv !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bad_header: got sync_err=%b pv=%b expected 1 0", cse, cpv);
      end
      @(negedge clk);
      checks++;
      if (cse !== 1'b0 || int'(cn) !== m_n[sel]) begin
         failures++;
         $display("[TB] FAIL bad_header_after: got sync_err=%b cnt=%0d expected 0 %0d",
                  cse, cn, m_n[sel]);
      end
   endtask

   task automatic test_timeout();
      int c;
      bit seen;
      sel = 1'b0;
      @(negedge clk); tb_byte = 8'h08; tb_valid = 1'b1;
      @(negedge clk); tb_byte = 8'h05;
      @(negedge clk); tb_valid = 1'b0;
      seen = 1'b0; c = 0;
      while (!seen && c < TMO + 10) begin
         @(negedge clk);
         c++;
         if (cse) seen = 1'b1;
      end
      checks++;
      if (!seen || c < TMO - 1 || c > TMO + 1) begin
         failures++;
         $display("[TB] FAIL timeout: got seen=%b after %0d idle cycles expected 1 after %0d",
                  seen, c, TMO);
      end
      checks++;
      if (int'(cn) !== m_n[sel]) begin
         failures++;
         $display("[TB] FAIL timeout_drop: got cnt=%0d expected %0d", cn, m_n[sel]);
      end
      send_packet(8'h08, 8'h05, 8'h00, 8'h00, 1'b0, "after_timeout");
   endtask

   task automatic test_buttons();
      sel = 1'b0;
      send_packet(8'h09, 8'h00, 8'h00, 8'h00, 1'b0, "left_press");
      send_packet(8'h09, 8'h00, 8'h00, 8'h00, 1'b0, "left_hold");
      send_packet(8'h08, 8'h00, 8'h00, 8'h00, 1'b0, "left_release");
      send_packet(8'h0E, 8'h00, 8'h00, 8'h00, 1'b0, "right_mid");
      checks++;
      if (cl !== 1'b0 || cr !== 1'b1 || cm !== 1'b1) begin
         failures++;
         $display("[TB] FAIL button_map: got l=%b r=%b m=%b expected 0 1 1", cl, cr, cm);
      end
   endtask

   task automatic test_random(input int count);
      logic [7:0] b0;
      for (int i = 0; i < count; i++) begin
         b0 = 8'($urandom) | 8'h08;
         send_packet(b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                     sel ? "rand4" : "rand3");
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      logic [7:0] pk[3];
      sel = 1'b0;
      pulses = 0;
      for (int p = 0; p < 8; p++) begin
         pk[0] = 8'($urandom) | 8'h08;
         pk[1] = 8'($urandom);
         pk[2] = 8'($urandom);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpv) pulses++;
            tb_byte  = pk[i];
            tb_valid = 1'b1;
         end
         model_apply(pk[0], pk[1], pk[2], 8'h00, 1'b0);
      end
      @(negedge clk);
      if (cpv) pulses++;
      tb_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (cpv) pulses++;
      end
      checks++;
      if (pulses != 8 || int'(cn) !== m_n[sel]) begin
         failures++;
         $display("[TB] FAIL back_to_back_cnt: got pulses=%0d cnt=%0d expected 8 %0d",
                  pulses, cn, m_n[sel]);
      end
      checks++;
      if (cx !== 10'(m_x[sel]) || cy !== 10'(m_y[sel]) || {cm, cr, cl} !== m_btn[sel]) begin
         failures++;
         $display("[TB] FAIL back_to_back_state: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                  cx, cy, {cm, cr, cl}, m_x[sel], m_y[sel], m_btn[sel]);
      end
   endtask

   task automatic test_wheel();
      sel = 1'b1;
      for (int i = 0; i < 20; i++)
         send_packet(8'h08, 8'h00, 8'h00, 8'h07, 1'b0, "wheel_up");
      checks++;
      if (cw !== 8'h7F || cn !== 16'd20) begin
         failures++;
         $display("[TB] FAIL wheel_sat: got w=%0d cnt=%0d expected 127 20", $signed(cw), cn);
      end
      checks++;
      if (w3 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL wheel_3byte: got %0d expected 0", w3);
      end
   endtask

   task automatic test_clear();
      sel = 1'b1;
      send_packet(8'h09, 8'h40, 8'h40, 8'h0F, 1'b0, "pre_clear");
      send_packet(8'h0A, 8'h10, 8'h00, 8'h0F, 1'b1, "clear_in_apply");
      checks++;
      if (cx !== 10'd320 || cy !== 10'd240 || cn !== 16'd22) begin
         failures++;
         $display("[TB] FAIL clear: got x=%0d y=%0d cnt=%0d expected 320 240 22", cx, cy, cn);
      end
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_motion();
      test_sync_err();
      test_timeout();
      test_buttons();
      sel = 1'b0;
      test_random(30);
      test_back_to_back();
      test_wheel();
      test_clear();
      sel = 1'b1;
      test_random(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
